// File: rtl/nibble_serial_addsub_ctrl_if.sv
// rtl/nibble_serial_addsub_ctrl_if.sv - operand/result handshake bundle for the nibble-serial add/sub sequencer
interface nibble_serial_addsub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operations and reads results.
  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, sum, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - WIDTH-bit add/sub done one 4-bit step per cycle, LS nibble first
module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  nibble_serial_addsub_ctrl_if.slave    bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already conditionally inverted for subtraction
  logic [WIDTH-1:0] r_partial;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_nib;
  logic [WIDTH-1:0] w_full;
  logic             w_ovf;

  // Single shared 4-bit step: current nibble of A and B' plus the running carry.
  always_comb begin
    w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    w_b_nib = r_b[{r_idx, 2'b00} +: 4];
    w_nib   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    w_full  = r_partial;
    w_full[{r_idx, 2'b00} +: 4] = w_nib[3:0];
    w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Sequencer FSM with all outputs registered; results publish only on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // DONE always lasts one cycle, even with ena low; a start here chains directly.
          r_done <= 1'b0;
          if (ena && bus.start) begin
            r_a       <= bus.op_a;
            r_b       <= bus.op_b ^ {WIDTH{bus.sub}};
            r_carry   <= bus.sub;
            r_idx     <= '0;
            r_partial <= '0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (ena) begin
            r_partial <= w_full;
            r_carry   <= w_nib[4];
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_sum   <= w_full;
              r_cout  <= w_nib[4];
              r_ovf   <= w_ovf;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - directed self-checking bench for the nibble-serial add/sub sequencer
module tb_nibble_serial_addsub_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;
  logic ena;
  int   n_checks;
  int   n_errors;

  nibble_serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; returns edges consumed.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_a  = 16'hDEAD;
    bus.op_b  = 16'hBEEF;
    bus.sub   = ~s;
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_no_early_done"}, 32'(bus.done), 32'd0);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(NIB));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    tick();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_sum_held"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  logic [15:0] bb_a   [3];
  logic [15:0] bb_b   [3];
  logic        bb_s   [3];
  logic [15:0] bb_sum [3];
  logic        bb_c   [3];

  initial begin
    int lat;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow",16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Stall: ena low for 3 cycles after the second nibble; a start during busy is ignored.
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_no_done", 32'(bus.done), 32'd0);
      check("stall_sum_prev", 32'(bus.sum), 32'h7FFF);
    end
    ena       = 1'b1;
    bus.op_a  = 16'hFFFF;
    bus.op_b  = 16'hFFFF;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check("stall_latency_rest", 32'(lat), 32'd1);
    check("stall_sum", 32'(bus.sum), 32'h3333);
    check("stall_cout", 32'(bus.cout), 32'd0);
    tick();
    check("ignored_start_busy", 32'(bus.busy), 32'd0);
    check("ignored_start_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-operation: outputs clear at once and nothing is published.
    bus.op_a  = 16'hAAAA;
    bus.op_b  = 16'h5555;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_sum",  32'(bus.sum),  32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    check("midrst_ovf",  32'(bus.ovf),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("postrst_no_done", 32'(bus.done), 32'd0);
    run_op("postrst_add", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Start held high: each DONE cycle accepts the next operands.
    bb_a[0] = 16'h0001; bb_b[0] = 16'h0002; bb_s[0] = 1'b0; bb_sum[0] = 16'h0003; bb_c[0] = 1'b0;
    bb_a[1] = 16'h0010; bb_b[1] = 16'h0001; bb_s[1] = 1'b1; bb_sum[1] = 16'h000F; bb_c[1] = 1'b1;
    bb_a[2] = 16'hF000; bb_b[2] = 16'h2000; bb_s[2] = 1'b0; bb_sum[2] = 16'h1000; bb_c[2] = 1'b1;
    bus.op_a  = bb_a[0];
    bus.op_b  = bb_b[0];
    bus.sub   = bb_s[0];
    bus.start = 1'b1;
    tick();
    bus.op_a = bb_a[1];
    bus.op_b = bb_b[1];
    bus.sub  = bb_s[1];
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      check("b2b_latency", 32'(lat), 32'(NIB));
      check("b2b_sum", 32'(bus.sum), 32'(bb_sum[k]));
      check("b2b_cout", 32'(bus.cout), 32'(bb_c[k]));
      check("b2b_ovf", 32'(bus.ovf), 32'd0);
      tick();
      check("b2b_done_drop", 32'(bus.done), 32'd0);
      check("b2b_rerun", 32'(bus.busy), (k < 2) ? 32'd1 : 32'd0);
      if (k == 0) begin
        bus.op_a = bb_a[2];
        bus.op_b = bb_b[2];
        bus.sub  = bb_s[2];
      end else begin
        bus.start = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
